// File: rtl/apb_cmd_master.sv
// apb_cmd_master: FIFO-buffered APB master for NSLV slaves, with a wait-state timeout per transfer.
// Define APB_CMD_PSTRB_EN to carry per-command write strobes (cmd_strb in, pstrb out).
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned SW     = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [SW-1:0]            cmd_sel,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
`ifdef APB_CMD_PSTRB_EN
  input  logic [DATA_W/8-1:0]      cmd_strb,
  output logic [DATA_W/8-1:0]      pstrb,
`endif
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [NSLV-1:0]          psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [NSLV*DATA_W-1:0]   prdata,
  input  logic [NSLV-1:0]          pready,
  input  logic [NSLV-1:0]          pslverr
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StErr} state_e;
  state_e state_q, state_d;

  logic              mem_write [DEPTH];
  logic [SW-1:0]     mem_sel   [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push, pop, fifo_empty;

  logic [NSLV-1:0]   psel_q, psel_d, head_onehot;
  logic              penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              sel_ok, sel_ready, sel_err, fetch;
  logic [DATA_W-1:0] sel_rdata;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != (AW+1)'(DEPTH));
  assign push       = cmd_valid & cmd_ready;

  always_ff @(posedge pclk) begin
    if (push) begin
      mem_write[wr_ptr_q] <= cmd_write;
      mem_sel[wr_ptr_q]   <= cmd_sel;
      mem_addr[wr_ptr_q]  <= cmd_addr;
      mem_wdata[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Head select decode; an index with no matching slave becomes an error response.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NSLV; i++) head_onehot[i] = (mem_sel[rd_ptr_q] == SW'(i));
    sel_ok = |head_onehot;
  end

  // psel_q is one-hot during ACCESS, so it masks out every unselected slave.
  always_comb begin
    sel_ready = |(pready & psel_q);
    sel_err   = |(pslverr & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_rdata_d = '0;
    fetch       = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: fetch = 1'b1;
      StSetup: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        // pready on the last counted cycle still completes normally.
        if (sel_ready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (pwrite_q || sel_err) ? '0 : sel_rdata;
          fetch       = 1'b1;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          fetch       = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StErr: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        fetch       = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Completion and idle share the fetch path, giving back-to-back SETUP with no idle cycle.
    if (fetch) begin
      penable_d = 1'b0;
      if (fifo_empty) begin
        psel_d  = '0;
        state_d = StIdle;
      end else begin
        pop      = 1'b1;
        pwrite_d = mem_write[rd_ptr_q];
        paddr_d  = mem_addr[rd_ptr_q];
        pwdata_d = mem_wdata[rd_ptr_q];
        psel_d   = head_onehot;
        state_d  = sel_ok ? StSetup : StErr;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= StIdle;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_CMD_PSTRB_EN
  logic [DATA_W/8-1:0] mem_strb [DEPTH];
  logic [DATA_W/8-1:0] pstrb_q;

  always_ff @(posedge pclk) begin
    if (push) mem_strb[wr_ptr_q] <= cmd_strb;
  end

  always_ff @(posedge pclk) begin
    if (preset)   pstrb_q <= '0;
    else if (pop) pstrb_q <= mem_write[rd_ptr_q] ? mem_strb[rd_ptr_q] : '0;
  end

  assign pstrb = pstrb_q;
`else
  // No strobe path: every write is full width.
`endif

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = !fifo_empty || (state_q != StIdle);

endmodule
